// File: rtl/telemetry_scheduler.sv
// Round-robin arbiter that shares one serial_tx byte channel among four sensor
// controllers, emitting a 12-byte framed packet per grant.
module telemetry_scheduler #(
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [3:0]   req,
  input  logic [239:0] src_data,
  output logic [3:0]   grant,
  output logic [7:0]   tx_data,
  output logic         tx_new_data,
  input  logic         tx_busy,
  input  logic         tx_block,
  output logic         active,
  output logic [1:0]   cur_src,
  output logic [15:0]  pkt_count
);

  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_SEND, S_HOLD, S_GAP} state_e;

  state_e        state_q, state_d;
  logic [1:0]    last_q, last_d;
  logic [1:0]    cur_src_q, cur_src_d;
  logic [59:0]   snap_q, snap_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    chk_q, chk_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          hold_first_q, hold_first_d;
  logic [3:0]    grant_q, grant_d;
  logic          active_q, active_d;
  logic [15:0]   pkt_count_q, pkt_count_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [1:0]    pick_s;
  logic          send_fire_s;

  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] r);
    logic [1:0] pick;
    logic [1:0] cand;
    pick = last;
    // Scan downward so the nearest requester after 'last' is the final winner.
    for (int i = 4; i >= 1; i--) begin
      cand = last + 2'(i);
      if (r[cand]) pick = cand;
    end
    return pick;
  endfunction

  function automatic logic [7:0] pkt_byte(input logic [3:0] idx, input logic [1:0] src,
                                          input logic [59:0] snap, input logic [7:0] chk);
    case (idx)
      4'd0:    return SYNC_BYTE;
      4'd1:    return {6'b000000, src};
      4'd2:    return {4'h0, snap[19:16]};
      4'd3:    return snap[15:8];
      4'd4:    return snap[7:0];
      4'd5:    return {4'h0, snap[39:36]};
      4'd6:    return snap[35:28];
      4'd7:    return snap[27:20];
      4'd8:    return {4'h0, snap[59:56]};
      4'd9:    return snap[55:48];
      4'd10:   return snap[47:40];
      default: return chk;
    endcase
  endfunction

  assign pick_s      = rr_pick(last_q, req);
  assign send_fire_s = (state_q == S_SEND) && !tx_busy && !tx_block;

  // Next-state and datapath update for the packet FSM
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    cur_src_d    = cur_src_q;
    snap_d       = snap_q;
    idx_d        = idx_q;
    chk_d        = chk_q;
    tx_data_d    = tx_data_q;
    hold_first_d = hold_first_q;
    grant_d      = 4'b0000;
    active_d     = active_q;
    pkt_count_d  = pkt_count_q;
    gap_d        = gap_q;
    case (state_q)
      S_IDLE: begin
        if (enable && (|req)) begin
          cur_src_d = pick_s;
          grant_d   = 4'b0001 << pick_s;
          active_d  = 1'b1;
          state_d   = S_LATCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LATCH: begin
        snap_d    = src_data[int'(cur_src_q) * 60 +: 60];
        idx_d     = 4'd0;
        chk_d     = 8'd0;
        tx_data_d = SYNC_BYTE;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (send_fire_s) begin
          if (idx_q != 4'd0) begin
            chk_d = chk_q + tx_data_q;
          end else begin
            chk_d = chk_q;
          end
          hold_first_d = 1'b1;
          state_d      = S_HOLD;
        end else begin
          state_d = S_SEND;
        end
      end
      S_HOLD: begin
        // busy from serial_tx lags the strobe by one cycle, so skip that cycle.
        if (hold_first_q) begin
          hold_first_d = 1'b0;
        end else if (!tx_busy) begin
          if (idx_q == 4'd11) begin
            pkt_count_d = pkt_count_q + 16'd1;
            last_d      = cur_src_q;
            active_d    = 1'b0;
            gap_d       = '0;
            state_d     = S_GAP;
          end else begin
            idx_d     = idx_q + 4'd1;
            tx_data_d = pkt_byte(idx_q + 4'd1, cur_src_q, snap_q, chk_q);
            state_d   = S_SEND;
          end
        end else begin
          state_d = S_HOLD;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        active_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_q       <= 2'd3;
      cur_src_q    <= 2'd3;
      snap_q       <= 60'd0;
      idx_q        <= 4'd0;
      chk_q        <= 8'd0;
      tx_data_q    <= 8'd0;
      hold_first_q <= 1'b0;
      grant_q      <= 4'b0000;
      active_q     <= 1'b0;
      pkt_count_q  <= 16'd0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      cur_src_q    <= cur_src_d;
      snap_q       <= snap_d;
      idx_q        <= idx_d;
      chk_q        <= chk_d;
      tx_data_q    <= tx_data_d;
      hold_first_q <= hold_first_d;
      grant_q      <= grant_d;
      active_q     <= active_d;
      pkt_count_q  <= pkt_count_d;
      gap_q        <= gap_d;
    end
  end

  assign grant       = grant_q;
  assign tx_data     = tx_data_q;
  assign tx_new_data = send_fire_s;
  assign active      = active_q;
  assign cur_src     = cur_src_q;
  assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_telemetry_scheduler.sv
// Directed + randomized bench for telemetry_scheduler with a packet-level
// reference model and a reactive serial_tx busy responder.
module tb_telemetry_scheduler;

  localparam int GAP = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic [3:0]   req = 4'b0000;
  logic [239:0] src_data = '0;
  logic [3:0]   grant;
  logic [7:0]   tx_data;
  logic         tx_new_data;
  logic         tx_busy = 1'b0;
  logic         tx_block = 1'b0;
  logic         active;
  logic [1:0]   cur_src;
  logic [15:0]  pkt_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int viol = 0;
  bit prev_strobe = 1'b0;
  bit busy_pend = 1'b0;
  bit busy_en = 1'b1;
  int busy_left = 0;

  logic [19:0] fld [4][3];
  logic [7:0]  rx_q[$];
  int          rx_cyc[$];
  logic [3:0]  gr_q[$];
  int          gr_cyc[$];

  logic [1:0]  m_last = 2'd3;
  logic [15:0] m_count = 16'd0;
  logic [95:0] exp_v;
  logic [95:0] last_pkt;
  int          base = 0;
  int          gbase = 0;
  int          last_end_cyc = 0;

  telemetry_scheduler #(.SYNC_BYTE(8'hA5), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .src_data(src_data),
    .grant(grant), .tx_data(tx_data), .tx_new_data(tx_new_data),
    .tx_busy(tx_busy), .tx_block(tx_block), .active(active),
    .cur_src(cur_src), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Mid-cycle monitor: records strobed bytes and grants, flags protocol breaks
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_new_data) begin
        rx_q.push_back(tx_data);
        rx_cyc.push_back(cyc);
        if (tx_busy || tx_block || prev_strobe || !active) viol++;
        busy_pend = 1'b1;
      end
      if (grant != 4'b0000) begin
        gr_q.push_back(grant);
        gr_cyc.push_back(cyc);
        if (!$onehot(grant)) viol++;
      end
    end
    prev_strobe = rst_n && tx_new_data;
  end

  // serial_tx stand-in: busy rises the cycle after a strobe for 1..4 cycles
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      busy_left = 0;
      busy_pend = 1'b0;
    end else if (busy_pend) begin
      busy_pend = 1'b0;
      busy_left = busy_en ? int'($urandom_range(1, 4)) : 0;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    tx_busy = (busy_left > 0);
  end

  function automatic logic [95:0] exp_pkt(input logic [1:0] s, input logic [19:0] f0,
                                          input logic [19:0] f1, input logic [19:0] f2);
    logic [7:0]  b[12];
    logic [19:0] f[3];
    int          sum;
    logic [95:0] r;
    f[0] = f0; f[1] = f1; f[2] = f2;
    b[0] = 8'hA5;
    b[1] = {6'b000000, s};
    for (int k = 0; k < 3; k++) begin
      b[2 + 3 * k] = {4'h0, f[k][19:16]};
      b[3 + 3 * k] = f[k][15:8];
      b[4 + 3 * k] = f[k][7:0];
    end
    sum = 0;
    for (int i = 1; i <= 10; i++) sum += int'(b[i]);
    b[11] = 8'(sum % 256);
    r = '0;
    for (int i = 0; i < 12; i++) r = {r[87:0], b[i]};
    return r;
  endfunction

  function automatic logic [1:0] rr_next(input logic [1:0] last, input logic [3:0] r);
    for (int i = 1; i <= 4; i++) begin
      if (r[(int'(last) + i) % 4]) return 2'((int'(last) + i) % 4);
    end
    return last;
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++)
        src_data[i * 60 + k * 20 +: 20] = fld[i][k];
  endtask

  task automatic randomize_fields();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++)
        fld[i][k] = 20'($urandom);
    drive_data();
  endtask

  task automatic wait_rx(input string tag, input int n);
    int t;
    t = 0;
    while (rx_q.size() < n && t < 4000) begin
      step(1);
      t++;
    end
    check(tag, 96'(rx_q.size() >= n), 96'd1);
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] s, input bit drop);
    int t;
    exp_v = exp_pkt(s, fld[s][0], fld[s][1], fld[s][2]);
    base  = rx_q.size();
    gbase = gr_q.size();
    t = 0;
    while (gr_q.size() == gbase && t < 3000) begin
      step(1);
      t++;
    end
    check({tag, " grant"}, 96'((gr_q.size() > gbase) ? gr_q[gbase] : 4'b0000),
          96'(4'b0001 << s));
    check({tag, " cur_src"}, 96'(cur_src), 96'(s));
    if (drop) req[s] = 1'b0;
  endtask

  task automatic finish_packet(input string tag, input logic [1:0] s);
    wait_rx({tag, " bytes"}, base + 12);
    last_pkt = '0;
    for (int i = 0; i < 12; i++)
      last_pkt = {last_pkt[87:0], (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx};
    check({tag, " packet"}, last_pkt, exp_v);
    if (rx_q.size() >= base + 12) last_end_cyc = rx_cyc[base + 11];
    step(10);
    m_count = m_count + 16'd1;
    m_last  = s;
    check({tag, " pkt_count"}, 96'(pkt_count), 96'(m_count));
    check({tag, " single grant"}, 96'(gr_q.size()), 96'(gbase + 1));
  endtask

  task automatic random_packet(input string tag);
    logic [1:0] s;
    req = (req & 4'($urandom)) | 4'($urandom);
    if (req == 4'b0000) req[$urandom_range(0, 3)] = 1'b1;
    randomize_fields();
    s = rr_next(m_last, req);
    wait_grant(tag, s, 1'b1);
    fld[s][0] = 20'($urandom);
    fld[s][1] = 20'($urandom);
    drive_data();
    if ($urandom_range(0, 3) == 0) begin
      tx_block = 1'b1;
      step(int'($urandom_range(1, 20)));
      tx_block = 1'b0;
    end
    finish_packet(tag, s);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int set_cyc;
    int g0;
    int t;
    logic [1:0] s;

    randomize_fields();
    step(3);
    check("reset grant", 96'(grant), 96'(4'b0000));
    check("reset tx_new_data", 96'(tx_new_data), 96'd0);
    check("reset tx_data", 96'(tx_data), 96'(8'h00));
    check("reset active", 96'(active), 96'd0);
    check("reset cur_src", 96'(cur_src), 96'(2'd3));
    check("reset pkt_count", 96'(pkt_count), 96'(16'h0000));
    rst_n = 1'b1;
    enable = 1'b1;
    step(2);

    // Reference packet from source 2, with latency measurement.
    fld[2][0] = 20'hABCDE; fld[2][1] = 20'h01234; fld[2][2] = 20'hFFFFF;
    drive_data();
    req = 4'b0100;
    set_cyc = cyc;
    wait_grant("vec", 2'd2, 1'b1);
    check("vec grant latency", 96'(gr_cyc[gbase] - set_cyc), 96'd1);
    wait_rx("vec first byte", base + 1);
    check("vec strobe latency", 96'(rx_cyc[base] - gr_cyc[gbase]), 96'd1);
    finish_packet("vec", 2'd2);
    check("vec literal", last_pkt, 96'hA5020ABCDE0012340FFFFFF9);

    // Round-robin with all four requesting after a fresh reset.
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    m_last = 2'd3;
    m_count = 16'd0;
    randomize_fields();
    req = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      s = rr_next(m_last, req);
      wait_grant("rr", s, 1'b0);
      check("rr order", 96'(s), 96'((p % 4)));
      if (p > 0) check("rr gap", 96'((gr_cyc[gbase] - last_end_cyc) >= GAP + 2), 96'd1);
      finish_packet("rr", s);
    end
    req = 4'b0000;
    step(30);

    // Long tx_block stall after the 4th byte.
    randomize_fields();
    req = 4'b0010;
    s = rr_next(m_last, req);
    wait_grant("blk", s, 1'b1);
    wait_rx("blk 4 bytes", base + 4);
    tx_block = 1'b1;
    g0 = rx_q.size();
    step(500);
    check("blk no strobe", 96'(rx_q.size()), 96'(g0));
    tx_block = 1'b0;
    finish_packet("blk", s);

    // Asynchronous reset in the middle of the 7th byte strobe.
    randomize_fields();
    req = 4'b1000;
    s = rr_next(m_last, req);
    wait_grant("rst", s, 1'b1);
    wait_rx("rst 6 bytes", base + 6);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!tx_new_data && t < 200);
    check("rst strobe seen", 96'(tx_new_data), 96'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst tx_new_data", 96'(tx_new_data), 96'd0);
    check("rst active", 96'(active), 96'd0);
    check("rst pkt_count", 96'(pkt_count), 96'(16'h0000));
    check("rst cur_src", 96'(cur_src), 96'(2'd3));
    req = 4'b0000;
    m_last = 2'd3;
    m_count = 16'd0;
    step(2);
    rst_n = 1'b1;
    step(2);
    randomize_fields();
    req = 4'b0010;
    wait_grant("post rst", 2'd1, 1'b1);
    finish_packet("post rst", 2'd1);

    // enable dropped mid-packet with two sources pending.
    req = 4'b0011;
    s = rr_next(m_last, req);
    wait_grant("en", s, 1'b1);
    wait_rx("en 3 bytes", base + 3);
    enable = 1'b0;
    finish_packet("en", s);
    g0 = gr_q.size();
    step(100);
    check("en no grant", 96'(gr_q.size()), 96'(g0));
    enable = 1'b1;
    s = rr_next(m_last, req);
    wait_grant("en resume", s, 1'b1);
    finish_packet("en resume", s);

    // Randomized traffic with snapshot mutation and short stalls.
    for (int it = 0; it < 20; it++) random_packet("rand");

    // Counter wrap.
    force dut.pkt_count_q = 16'hFFFE;
    step(1);
    release dut.pkt_count_q;
    m_count = 16'hFFFE;
    random_packet("wrap a");
    random_packet("wrap b");
    check("wrap zero", 96'(pkt_count), 96'(16'h0000));

    req = 4'b0000;
    step(40);
    check("protocol violations", 96'(viol), 96'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/telemetry_scheduler.md
# telemetry_scheduler

Round-robin scheduler that shares the single serial_tx byte channel among four sensor controllers: altimeter, gyro, accelerometer and GPS. Each controller raises a request with a 60-bit snapshot (three 20-bit fields). The block grants one requester at a time, latches its snapshot and emits one framed 12-byte packet through the serial_tx new_data/busy/block handshake. It sits between the sensor controllers and serial_tx in mojo_top.

## Interface
- SYNC_BYTE, 8'hA5, first byte of every packet
- GAP_CYCLES, 16, idle clk cycles enforced after each packet (≥1)
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  when 0, no new grants; a packet in flight completes
- req  in  4  per-source level request; held until that source's grant pulse
- src_data  in  240  source i fields at [i*60 +: 60]; field k = [i*60+k*20 +: 20]
- grant  out  4  one-hot, one-cycle pulse; src_data of that source latched this cycle
- tx_data  out  8  byte to serial_tx
- tx_new_data  out  1  one-cycle strobe, tx_data valid
- tx_busy  in  1  serial_tx busy
- tx_block  in  1  AVR back-pressure; no strobe while high
- active  out  1  high from LATCH through end of SEND/HOLD
- cur_src  out  2  source being served (last served when idle)
- pkt_count  out  16  packets completed, wraps 16'hFFFF→0

## Operation
- Packet, 12 bytes, in order:
  - SYNC_BYTE
  - ID = {6'b0, src}
  - field0, field1, field2, each as {4'h0, f[19:16]}, f[15:8], f[7:0]
  - CHK = 8-bit sum mod 256 of the ID byte and all 9 payload bytes; SYNC is excluded.
- FSM states and transitions:
  - IDLE: if enable && |req, pick the first asserted req scanning from last+1 mod 4 upward; register cur_src; go to LATCH.
  - LATCH, one cycle: grant[cur_src]=1; snapshot 60 bits; byte index=0; checksum=0; active=1; go to SEND.
  - SEND: when !tx_busy && !tx_block, pulse tx_new_data with byte[index] and accumulate the checksum; go to HOLD.
  - HOLD: ignore tx_busy for the first cycle, because serial_tx registers busy. Then wait for !tx_busy.
    - If index==11: pkt_count++, last=cur_src, go to GAP.
    - Otherwise: index++, go to SEND.
  - GAP: count GAP_CYCLES, then go to IDLE.
- Arbitration:
  - last resets to 3, so the first grant after reset favours source 0.
  - A source that drops req before being granted is skipped; no error is raised.
- enable:
  - Sampled only in IDLE.
  - Deasserting it mid-packet does not truncate the packet.
- Snapshot: src_data changes after LATCH do not affect the packet in flight.

## Timing
- Reset values:
  - grant=0, tx_new_data=0, tx_data=0, active=0, cur_src=3, pkt_count=0
  - state=IDLE, last=3
- Reset asserted mid-packet: outputs go to reset values immediately and asynchronously. The partial packet is abandoned; it is not resumed.
- Latency: req sampled in IDLE at edge N → grant at cycle N+1 → first tx_new_data at cycle N+2 if the channel is free.
- Byte spacing: at least 2 cycles between strobes, plus the serial_tx busy time.
- tx_block or tx_busy high in SEND: stall indefinitely with no strobe; the byte index is held.
- Simultaneous requests: only one grant per packet. Other requests stay pending.
- A request arriving during SEND/HOLD/GAP is served after GAP.
- At most one tx_new_data per HOLD round; never two consecutive cycles.

## Test plan
- Source 2 fields 20'hABCDE, 20'h01234, 20'hFFFFF, req=4'b0100 → grant=4'b0100 for one cycle; bytes A5 02 0A BC DE 00 12 34 0F FF FF F9; pkt_count=1.
- req=4'b1111 held, re-raised after each grant → service order 0,1,2,3,0; GAP_CYCLES idle cycles between packets.
- Hold tx_block=1 for 500 cycles after the 4th byte → no strobes during the block; on release the 5th byte is sent; the packet is intact with a correct CHK.
- Assert rst_n=0 after the 6th byte → tx_new_data=0 and active=0 the same cycle. After release, req source 1 → a full fresh packet starting with A5 01.
- enable=0 mid-packet with req=4'b0011 → the current packet completes; no grant while enable=0; the next grant occurs after enable=1.
- Preload pkt_count near wrap by sending 65536 packets (or force) → the count wraps to 0 with no other side effects.
